muldiv_ctrl: RTL and testbench

Sequencing controller for the core's HI/LO unit. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands from the execute stage. Multiplies run through the core's combinational 32x32 multiplier `mult` (inputs a, b, sign; 64-bit output) with a registered result. Divides run through a 32-iteration radix-2 restoring divider. The block owns the architectural HI/LO registers and raises `busy` so the pipeline stalls until results are committed.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_if.sv | 33 +++
 rtl/div_radix2_step.sv | 28 ++
 rtl/mult.sv | 22 ++
 rtl/muldiv_ctrl.sv | 158 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 252 +++++++++++++++++++++++++
 6 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and constants for the HI/LO multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Command codes from the execute stage; 7 decodes as NOP.
    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6
    } op_e;

    // Sequencer states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Quotient produced by a divide by zero.
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    // Magnitude of a 32-bit operand; only negated when treated as signed.
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_if
// Description : Command/result bundle between execute stage and HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_if;
    import muldiv_pkg::*;

    logic        start;
    op_e         op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    // Execute stage side.
    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    // HI/LO unit side.
    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo
    );

endinterface
`default_nettype wire

// File: rtl/div_radix2_step.sv
`default_nettype none
// ============================================================================
// Module      : div_radix2_step
// Description : One combinational restoring-division iteration (radix 2).
// Revision    : 1.0 - initial release
// ============================================================================
module div_radix2_step (
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out
);
    logic [32:0] w_shifted;
    logic        w_ge;
    logic [31:0] w_sub;

    // Bring the next dividend bit into the partial remainder. The shifted
    // value can reach 33 bits, so the compare is done at that width; when it
    // succeeds the difference is below the divisor and fits in 32 bits.
    assign w_shifted = {rem_in, quo_in[31]};
    assign w_ge      = (w_shifted >= {1'b0, divisor});
    assign w_sub     = w_shifted[31:0] - divisor;
    assign rem_out   = w_ge ? w_sub : w_shifted[31:0];
    assign quo_out   = {quo_in[30:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/mult.sv
`default_nettype none
// ============================================================================
// Module      : mult
// Description : Combinational 32x32 multiplier, signed or unsigned, 64-bit out.
// Revision    : 1.0 - initial release
// ============================================================================
module mult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sign,
    output logic [63:0] p
);
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;

    // Sign-extend to 64 bits; the low 64 bits of the product are then exact.
    assign w_a_ext = {{32{sign & a[31]}}, a};
    assign w_b_ext = {{32{sign & b[31]}}, b};
    assign p       = w_a_ext * w_b_ext;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : HI/LO sequencer: one-cycle multiply, 32-cycle restoring
//               divide with sign fixup, MTHI/MTLO, flush and stall signalling.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);
    localparam int                 c_cnt_w    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DIV_CYCLES - 1);

    state_e             r_state;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic               r_mul_sign;
    logic [31:0]        r_rem;
    logic [31:0]        r_quo;
    logic [31:0]        r_dvsr;
    logic               r_q_neg;
    logic               r_r_neg;
    logic [c_cnt_w-1:0] r_cnt;

    logic [63:0]        w_prod;
    logic [31:0]        w_rem_nxt;
    logic [31:0]        w_quo_nxt;
    logic               w_div_signed;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic               w_dvsr_zero;

    // Multiplier sees only the latched operands, so its output is stable in MUL.
    mult u_mult (
        .a    (r_mul_a),
        .b    (r_mul_b),
        .sign (r_mul_sign),
        .p    (w_prod)
    );

    div_radix2_step u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .divisor (r_dvsr),
        .rem_out (w_rem_nxt),
        .quo_out (w_quo_nxt)
    );

    assign w_div_signed = (bus.op == OP_DIV);
    assign w_abs_a      = mag32(bus.src_a, w_div_signed);
    assign w_abs_b      = mag32(bus.src_b, w_div_signed);
    assign w_dvsr_zero  = (r_dvsr == 32'd0);

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // Sequencer: command accept, divide iterations, result commit and flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_mul_a    <= 32'd0;
            r_mul_b    <= 32'd0;
            r_mul_sign <= 1'b0;
            r_rem      <= 32'd0;
            r_quo      <= 32'd0;
            r_dvsr     <= 32'd0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                // Squash: drop whatever is in flight or arriving, no HI/LO write.
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            case (bus.op)
                                OP_MULT, OP_MULTU: begin
                                    r_mul_a    <= bus.src_a;
                                    r_mul_b    <= bus.src_b;
                                    r_mul_sign <= (bus.op == OP_MULT);
                                    r_state    <= ST_MUL;
                                    r_busy     <= 1'b1;
                                end
                                OP_DIV, OP_DIVU: begin
                                    r_quo   <= w_abs_a;
                                    r_dvsr  <= w_abs_b;
                                    r_rem   <= 32'd0;
                                    r_q_neg <= w_div_signed & (bus.src_a[31] ^ bus.src_b[31]);
                                    r_r_neg <= w_div_signed & bus.src_a[31];
                                    r_cnt   <= c_cnt_last;
                                    r_state <= ST_DIV;
                                    r_busy  <= 1'b1;
                                end
                                OP_MTHI: r_hi <= bus.src_a;
                                OP_MTLO: r_lo <= bus.src_a;
                                default: ;
                            endcase
                        end
                    end
                    ST_MUL: begin
                        {r_hi, r_lo} <= w_prod;
                        r_done       <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                    end
                    ST_DIV: begin
                        r_rem <= w_rem_nxt;
                        r_quo <= w_quo_nxt;
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == '0) begin
                            r_state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        // A zero divisor leaves the all-ones quotient untouched;
                        // the remainder still gets its sign back so HI equals
                        // the original dividend in both signed and unsigned forms.
                        if (w_dvsr_zero) begin
                            r_lo <= DIV_ZERO_Q;
                        end else begin
                            r_lo <= r_q_neg ? (~r_quo + 32'd1) : r_quo;
                        end
                        r_hi    <= r_r_neg ? (~r_rem + 32'd1) : r_rem;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Directed self-checking bench for the HI/LO sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   nbusy;

    muldiv_if bus ();

    muldiv_ctrl #(
        .DIV_CYCLES (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one command at a falling edge, then count busy cycles (bounded).
    // Returns at the first falling edge where busy is low.
    task automatic run_op(input op_e o, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        for (int i = 0; i < 50 && bus.busy === 1'b1; i++) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        bus.flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MULT -2 * 3
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, nbusy);
        check("mult_busy_cycles", 32'(nbusy), 32'd1);
        check("mult_done", {31'd0, bus.done}, 32'd1);
        check("mult_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo, 32'hFFFF_FFFA);

        // MULTU accepted in the cycle the previous result appears
        run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, nbusy);
        check("multu_busy_cycles", 32'(nbusy), 32'd1);
        check("multu_done", {31'd0, bus.done}, 32'd1);
        check("multu_hi", bus.hi, 32'h0000_0002);
        check("multu_lo", bus.lo, 32'hFFFF_FFFA);
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);

        // DIV -7 / 2
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, nbusy);
        check("div_busy_cycles", 32'(nbusy), 32'd33);
        check("div_done", {31'd0, bus.done}, 32'd1);
        check("div_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_hi", bus.hi, 32'hFFFF_FFFF);

        // DIVU 7 / 2
        run_op(OP_DIVU, 32'd7, 32'd2, nbusy);
        check("divu_busy_cycles", 32'(nbusy), 32'd33);
        check("divu_lo", bus.lo, 32'd3);
        check("divu_hi", bus.hi, 32'd1);

        // DIV 7 / -2
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, nbusy);
        check("div_negdvsr_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_negdvsr_hi", bus.hi, 32'd1);

        // Signed overflow
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, nbusy);
        check("div_ovf_lo", bus.lo, 32'h8000_0000);
        check("div_ovf_hi", bus.hi, 32'd0);

        // Divide by zero
        run_op(OP_DIVU, 32'h0000_1234, 32'd0, nbusy);
        check("divz_busy_cycles", 32'(nbusy), 32'd33);
        check("divz_lo", bus.lo, 32'hFFFF_FFFF);
        check("divz_hi", bus.hi, 32'h0000_1234);

        // Ignored start at cycle 10, flush at cycle 20 of a DIV
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(negedge clk);                 // cycle 1
        bus.start = 1'b0;
        repeat (9) @(negedge clk);      // cycle 10
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.src_a = 32'd5;
        bus.src_b = 32'd5;
        @(negedge clk);                 // cycle 11
        bus.start = 1'b0;
        check("ign_start_busy", {31'd0, bus.busy}, 32'd1);
        repeat (9) @(negedge clk);      // cycle 20
        check("pre_flush_busy", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(negedge clk);                 // cycle 21
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.busy}, 32'd0);
        check("flush_done", {31'd0, bus.done}, 32'd0);
        check("flush_hi", bus.hi, 32'h0000_1234);
        check("flush_lo", bus.lo, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_flush_done", {31'd0, bus.done}, 32'd0);
            check("post_flush_busy", {31'd0, bus.busy}, 32'd0);
        end
        check("post_flush_lo", bus.lo, 32'hFFFF_FFFF);

        // MTHI then MTLO on consecutive cycles
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);
        bus.op    = OP_MTLO;
        bus.src_a = 32'h0BAD_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo_lo", bus.lo, 32'h0BAD_F00D);
        check("mtlo_hi", bus.hi, 32'hDEAD_BEEF);
        check("mtlo_busy", {31'd0, bus.busy}, 32'd0);
        check("mtlo_done", {31'd0, bus.done}, 32'd0);

        // Flush and start together: command dropped
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = OP_MTHI;
        bus.src_a = 32'h1234_5678;
        @(negedge clk);
        bus.op    = OP_MULT;
        bus.src_a = 32'd9;
        bus.src_b = 32'd9;
        check("flush_mthi_hi", bus.hi, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_mult_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("flush_mult_lo", bus.lo, 32'h0BAD_F00D);

        // Code 7 behaves as NOP
        bus.start = 1'b1;
        bus.op    = op_e'(3'd7);
        bus.src_a = 32'hFFFF_0000;
        @(negedge clk);
        bus.start = 1'b0;
        check("op7_busy", {31'd0, bus.busy}, 32'd0);
        check("op7_hi", bus.hi, 32'hDEAD_BEEF);

        // Asynchronous reset mid-MUL
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.src_a = 32'd5;
        bus.src_b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("mid_mul_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_mul_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_mul_hi", bus.hi, 32'd0);
        check("arst_mul_lo", bus.lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_mul_done", {31'd0, bus.done}, 32'd0);

        // Asynchronous reset mid-DIV
        bus.start = 1'b1;
        bus.op    = OP_MTHI;
        bus.src_a = 32'h0000_0055;
        @(negedge clk);
        bus.op    = OP_DIVU;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_div_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_div_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_div_hi", bus.hi, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // First commands after release complete with normal latency
        run_op(OP_MULTU, 32'd5, 32'd6, nbusy);
        check("post_rst_mul_cycles", 32'(nbusy), 32'd1);
        check("post_rst_mul_done", {31'd0, bus.done}, 32'd1);
        check("post_rst_mul_lo", bus.lo, 32'd30);
        check("post_rst_mul_hi", bus.hi, 32'd0);
        run_op(OP_DIVU, 32'd100, 32'd7, nbusy);
        check("post_rst_div_cycles", 32'(nbusy), 32'd33);
        check("post_rst_div_lo", bus.lo, 32'd14);
        check("post_rst_div_hi", bus.hi, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
